// File: rtl/conv_input_interface.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// conv_input_interface
//
// Input-side data mover for the convolution layer. It holds a
// KERNEL_SIZE x KERNEL_SIZE pixel window that is filled from the feature-map
// memory and streamed, one window row per cycle, to the kernel array.
//
// Command / acknowledge handshake with the layer controller:
//   cmd is sampled only while the FSM is IDLE. A non-IDLE code starts the
//   matching operation, and any cmd seen while busy is ignored. When the
//   operation is complete, ack carries the matching *_FIN code for exactly
//   one cycle. The controller may issue its next command in the cycle after
//   that ack.
//
// Memory read protocol:
//   mem_rd_en/mem_rd_addr are registered. mem_rd_data is valid exactly one
//   cycle after mem_rd_en.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   cmd          command: IDLE=0, PRELOAD=1, SHIFT=2, LOAD=3
//   ack          acknowledge: IDLE=0, PRELOAD_FIN=1, SHIFT_FIN=2, LOAD_FIN=3
//   mem_rd_en    memory read strobe
//   mem_rd_addr  read address (row * IMG_WIDTH + col)
//   mem_rd_data  read data, one cycle after mem_rd_en
//   row_out      one window row, column 0 in the LSBs
//   row_valid    row_out is valid
//   row_sel      index of the window row currently on row_out
//   frame_done   one-cycle pulse when the row band wraps
//   cmd_err      (only with CONV_INPUT_CMD_CHECK_EN) one-cycle pulse when a
//                command arrives while busy, or on a LOAD at the right edge
//
// Optional feature macro: CONV_INPUT_CMD_CHECK_EN
// -----------------------------------------------------------------------------
module conv_input_interface #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 6,
    parameter int IMG_HEIGHT  = 6,
    parameter int ADDR_WIDTH  = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        cmd,
    output logic [1:0]                        ack,
    output logic                              mem_rd_en,
    output logic [ADDR_WIDTH-1:0]             mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]             mem_rd_data,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0] row_out,
    output logic                              row_valid,
    output logic [1:0]                        row_sel,
    output logic                              frame_done
`ifdef CONV_INPUT_CMD_CHECK_EN
   ,output logic                              cmd_err
`endif
);

    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

    // Last legal top row of a band and last legal left column of the window.
    localparam logic [RW-1:0] BAND_LAST = RW'(IMG_HEIGHT - KERNEL_SIZE);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - KERNEL_SIZE);
    localparam logic [KW-1:0] K_LAST    = KW'(KERNEL_SIZE - 1);
    localparam logic [1:0]    SEL_LAST  = 2'(KERNEL_SIZE - 1);

    localparam logic [1:0] CMD_IDLE    = 2'd0;
    localparam logic [1:0] CMD_PRELOAD = 2'd1;
    localparam logic [1:0] CMD_SHIFT   = 2'd2;
    localparam logic [1:0] CMD_LOAD    = 2'd3;

    localparam logic [1:0] ACK_IDLE        = 2'd0;
    localparam logic [1:0] ACK_PRELOAD_FIN = 2'd1;
    localparam logic [1:0] ACK_SHIFT_FIN   = 2'd2;
    localparam logic [1:0] ACK_LOAD_FIN    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRELOAD = 3'd1,
        S_SHIFT   = 3'd2,
        S_LOAD    = 3'd3,
        S_ACK     = 3'd4
    } state_t;

    state_t                              state_q;
    logic [1:0]                          ack_q;
    logic                                mem_rd_en_q;
    logic [ADDR_WIDTH-1:0]               mem_rd_addr_q;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0]   row_out_q;
    logic                                row_valid_q;
    logic [1:0]                          row_sel_q;
    logic                                frame_done_q;
`ifdef CONV_INPUT_CMD_CHECK_EN
    logic                                cmd_err_q;
`endif

    // Marks that mem_rd_data carries the reply to last cycle's read.
    logic                                rd_vld_q;

    // Window row/column of the read currently on the bus, and of the reply
    // being captured. They differ by one read because of memory latency.
    logic [KW-1:0]                       iss_r_q;
    logic [KW-1:0]                       iss_c_q;
    logic [KW-1:0]                       cap_r_q;
    logic [KW-1:0]                       cap_c_q;

    // row_base is the band the next PRELOAD fetches. band_q is the band the
    // window actually holds, which LOAD needs after row_base has advanced.
    logic [RW-1:0]                       row_base_q;
    logic [RW-1:0]                       band_q;
    logic [CW-1:0]                       col_base_q;

    logic [DATA_WIDTH-1:0]               win_q [KERNEL_SIZE][KERNEL_SIZE];

    // Next-state helpers
    logic [KW-1:0]                       iss_r_d;
    logic [KW-1:0]                       iss_c_d;
    logic [ADDR_WIDTH-1:0]               pre_addr_d;
    logic [ADDR_WIDTH-1:0]               load_addr_d;
    logic [1:0]                          sel_next;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0]   row_first_d;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0]   row_next_d;

    function automatic logic [ADDR_WIDTH-1:0] pix_addr(
        input logic [ADDR_WIDTH-1:0] row,
        input logic [ADDR_WIDTH-1:0] col
    );
        return row * ADDR_WIDTH'(IMG_WIDTH) + col;
    endfunction

    // Raster-order successor of the current PRELOAD read and the addresses
    // of the next PRELOAD / LOAD reads.
    always_comb begin
        iss_c_d     = iss_c_q + KW'(1);
        iss_r_d     = iss_r_q;
        if (iss_c_q == K_LAST) begin
            iss_c_d = '0;
            iss_r_d = iss_r_q + KW'(1);
        end
        pre_addr_d  = pix_addr(ADDR_WIDTH'(row_base_q) + ADDR_WIDTH'(iss_r_d),
                               ADDR_WIDTH'(iss_c_d));
        load_addr_d = pix_addr(ADDR_WIDTH'(band_q) + ADDR_WIDTH'(iss_r_q) + ADDR_WIDTH'(1),
                               ADDR_WIDTH'(col_base_q) + ADDR_WIDTH'(KERNEL_SIZE));
    end

    assign sel_next = row_sel_q + 2'd1;

    // Packed window rows for SHIFT: row 0 at the start, and the row after
    // the one currently presented.
    always_comb begin
        row_first_d = '0;
        row_next_d  = '0;
        for (int c = 0; c < KERNEL_SIZE; c++) begin
            row_first_d[c*DATA_WIDTH +: DATA_WIDTH] = win_q[0][c];
            row_next_d[c*DATA_WIDTH +: DATA_WIDTH]  = win_q[sel_next][c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ack_q         <= ACK_IDLE;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            row_out_q     <= '0;
            row_valid_q   <= 1'b0;
            row_sel_q     <= '0;
            frame_done_q  <= 1'b0;
`ifdef CONV_INPUT_CMD_CHECK_EN
            cmd_err_q     <= 1'b0;
`endif
            rd_vld_q      <= 1'b0;
            iss_r_q       <= '0;
            iss_c_q       <= '0;
            cap_r_q       <= '0;
            cap_c_q       <= '0;
            row_base_q    <= '0;
            band_q        <= '0;
            col_base_q    <= '0;
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            rd_vld_q <= mem_rd_en_q;
`ifdef CONV_INPUT_CMD_CHECK_EN
            // A command while busy is only flagged; the FSM never reacts to it.
            cmd_err_q <= (state_q != S_IDLE) && (cmd != CMD_IDLE);
`endif
            case (state_q)
                S_IDLE: begin
                    ack_q        <= ACK_IDLE;
                    frame_done_q <= 1'b0;
                    case (cmd)
                        CMD_PRELOAD: begin
                            state_q       <= S_PRELOAD;
                            col_base_q    <= '0;
                            mem_rd_en_q   <= 1'b1;
                            mem_rd_addr_q <= pix_addr(ADDR_WIDTH'(row_base_q), '0);
                            iss_r_q       <= '0;
                            iss_c_q       <= '0;
                            cap_r_q       <= '0;
                            cap_c_q       <= '0;
                        end
                        CMD_SHIFT: begin
                            state_q     <= S_SHIFT;
                            row_valid_q <= 1'b1;
                            row_sel_q   <= '0;
                            row_out_q   <= row_first_d;
                        end
                        CMD_LOAD: begin
                            if (col_base_q == COL_LAST) begin
                                // Window already at the right edge: nothing
                                // to fetch, acknowledge straight away.
                                state_q <= S_ACK;
                                ack_q   <= ACK_LOAD_FIN;
`ifdef CONV_INPUT_CMD_CHECK_EN
                                cmd_err_q <= 1'b1;
`endif
                            end else begin
                                state_q       <= S_LOAD;
                                mem_rd_en_q   <= 1'b1;
                                mem_rd_addr_q <= pix_addr(ADDR_WIDTH'(band_q),
                                                          ADDR_WIDTH'(col_base_q) + ADDR_WIDTH'(KERNEL_SIZE));
                                iss_r_q       <= '0;
                                cap_r_q       <= '0;
                            end
                        end
                        default: ;
                    endcase
                end

                S_PRELOAD: begin
                    if (mem_rd_en_q) begin
                        if ((iss_r_q == K_LAST) && (iss_c_q == K_LAST)) begin
                            mem_rd_en_q   <= 1'b0;
                            mem_rd_addr_q <= '0;
                        end else begin
                            iss_r_q       <= iss_r_d;
                            iss_c_q       <= iss_c_d;
                            mem_rd_addr_q <= pre_addr_d;
                        end
                    end
                    if (rd_vld_q) begin
                        win_q[cap_r_q][cap_c_q] <= mem_rd_data;
                        if ((cap_r_q == K_LAST) && (cap_c_q == K_LAST)) begin
                            state_q <= S_ACK;
                            ack_q   <= ACK_PRELOAD_FIN;
                            band_q  <= row_base_q;
                            if (row_base_q == BAND_LAST) begin
                                row_base_q   <= '0;
                                frame_done_q <= 1'b1;
                            end else begin
                                row_base_q   <= row_base_q + RW'(1);
                            end
                        end else if (cap_c_q == K_LAST) begin
                            cap_c_q <= '0;
                            cap_r_q <= cap_r_q + KW'(1);
                        end else begin
                            cap_c_q <= cap_c_q + KW'(1);
                        end
                    end
                end

                S_LOAD: begin
                    if (mem_rd_en_q) begin
                        if (iss_r_q == K_LAST) begin
                            mem_rd_en_q   <= 1'b0;
                            mem_rd_addr_q <= '0;
                        end else begin
                            iss_r_q       <= iss_r_q + KW'(1);
                            mem_rd_addr_q <= load_addr_d;
                        end
                    end
                    if (rd_vld_q) begin
                        // Each window row is shifted exactly once, as its new
                        // right-hand pixel arrives.
                        for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                            win_q[cap_r_q][c] <= win_q[cap_r_q][c+1];
                        end
                        win_q[cap_r_q][KERNEL_SIZE-1] <= mem_rd_data;
                        if (cap_r_q == K_LAST) begin
                            state_q    <= S_ACK;
                            ack_q      <= ACK_LOAD_FIN;
                            col_base_q <= col_base_q + CW'(1);
                        end else begin
                            cap_r_q <= cap_r_q + KW'(1);
                        end
                    end
                end

                S_SHIFT: begin
                    if (row_sel_q == SEL_LAST) begin
                        state_q     <= S_ACK;
                        ack_q       <= ACK_SHIFT_FIN;
                        row_valid_q <= 1'b0;
                        row_sel_q   <= '0;
                        row_out_q   <= '0;
                    end else begin
                        row_sel_q <= sel_next;
                        row_out_q <= row_next_d;
                    end
                end

                S_ACK: begin
                    state_q      <= S_IDLE;
                    ack_q        <= ACK_IDLE;
                    frame_done_q <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign row_out     = row_out_q;
    assign row_valid   = row_valid_q;
    assign row_sel     = row_sel_q;
    assign frame_done  = frame_done_q;
`ifdef CONV_INPUT_CMD_CHECK_EN
    assign cmd_err     = cmd_err_q;
`endif

endmodule

// File: tb/tb_conv_input_interface.sv
`timescale 1ns/1ps
// Bench for conv_input_interface with W=H=6, K=3 and memory[a]=a.
module tb_conv_input_interface;

  localparam int DW = 8;
  localparam int K  = 3;
  localparam int W  = 6;
  localparam int H  = 6;
  localparam int AW = 6;

  localparam logic [1:0] CMD_IDLE    = 2'd0;
  localparam logic [1:0] CMD_PRELOAD = 2'd1;
  localparam logic [1:0] CMD_SHIFT   = 2'd2;
  localparam logic [1:0] CMD_LOAD    = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] cmd = CMD_IDLE;

  logic [1:0]        ack;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  logic [DW-1:0]     mem_rd_data;
  logic [K*DW-1:0]   row_out;
  logic              row_valid;
  logic [1:0]        row_sel;
  logic              frame_done;
`ifdef CONV_INPUT_CMD_CHECK_EN
  logic              cmd_err;
`endif

  always #5 clk = ~clk;

  conv_input_interface #(
    .DATA_WIDTH (DW),
    .KERNEL_SIZE(K),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .ack        (ack),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .row_out    (row_out),
    .row_valid  (row_valid),
    .row_sel    (row_sel),
    .frame_done (frame_done)
`ifdef CONV_INPUT_CMD_CHECK_EN
   ,.cmd_err    (cmd_err)
`endif
  );

  // One-cycle-latency memory, memory[a] = a.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  // Read entries: {cycle, address}. Row entries: {cycle, row_sel, row_out}.
  logic [13:0] exp_rd_q[$];
  logic [33:0] exp_row_q[$];

  // Reference model of the window and pointers.
  int          m_rb;
  int          m_band;
  int          m_col;
  logic [7:0]  m_win [3][3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},        64'(ack),         64'd0);
    check({tag, "_rd_en"},      64'(mem_rd_en),   64'd0);
    check({tag, "_rd_addr"},    64'(mem_rd_addr), 64'd0);
    check({tag, "_row_out"},    64'(row_out),     64'd0);
    check({tag, "_row_valid"},  64'(row_valid),   64'd0);
    check({tag, "_row_sel"},    64'(row_sel),     64'd0);
    check({tag, "_frame_done"}, 64'(frame_done),  64'd0);
`ifdef CONV_INPUT_CMD_CHECK_EN
    check({tag, "_cmd_err"},    64'(cmd_err),     64'd0);
`endif
  endtask

  // Called at the falling edge of a cycle in which the DUT is IDLE (cycle 0).
  // Builds the expectations from the model, drives the command, optionally
  // injects a second command while busy, and monitors until ack.
  task automatic run_cmd(input logic [1:0] c, input int inj_cyc, input logic [1:0] inj_cmd);
    int         ack_cyc;
    logic [1:0] exp_ack;
    logic       exp_frame;
    int         edge_load;
    bit         got_ack;
    int         extra;
    int         frame_stray;
    int         err_cnt;
    int         exp_err;
    logic [13:0] e_rd;
    logic [33:0] e_row;

    ack_cyc = 0; exp_ack = 2'd0; exp_frame = 1'b0; edge_load = 0;
    got_ack = 1'b0; extra = 0; frame_stray = 0; err_cnt = 0;

    case (c)
      CMD_PRELOAD: begin
        for (int r = 0; r < K; r++) begin
          for (int cc = 0; cc < K; cc++) begin
            exp_rd_q.push_back({8'(1 + r*K + cc), 6'((m_rb + r)*W + cc)});
            m_win[r][cc] = 8'((m_rb + r)*W + cc);
          end
        end
        ack_cyc   = K*K + 2;
        exp_ack   = 2'd1;
        exp_frame = (m_rb == H - K);
        m_band    = m_rb;
        m_rb      = (m_rb == H - K) ? 0 : m_rb + 1;
        m_col     = 0;
      end
      CMD_LOAD: begin
        exp_ack = 2'd3;
        if (m_col + K == W) begin
          ack_cyc   = 1;
          edge_load = 1;
        end else begin
          for (int r = 0; r < K; r++) begin
            exp_rd_q.push_back({8'(1 + r), 6'((m_band + r)*W + m_col + K)});
            m_win[r][0] = m_win[r][1];
            m_win[r][1] = m_win[r][2];
            m_win[r][2] = 8'((m_band + r)*W + m_col + K);
          end
          ack_cyc = K + 2;
          m_col++;
        end
      end
      default: begin
        for (int r = 0; r < K; r++) begin
          exp_row_q.push_back({8'(1 + r), 2'(r), m_win[r][2], m_win[r][1], m_win[r][0]});
        end
        ack_cyc = K + 1;
        exp_ack = 2'd2;
      end
    endcase
    exp_err = edge_load + (((inj_cyc > 0) && (inj_cmd != CMD_IDLE)) ? 1 : 0);

    cmd = c;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      cmd = (cyc == inj_cyc) ? inj_cmd : CMD_IDLE;
      if (mem_rd_en) begin
        if (exp_rd_q.size() > 0) begin
          e_rd = exp_rd_q.pop_front();
          check("rd_cycle_addr", 64'({8'(cyc), mem_rd_addr}), 64'(e_rd));
        end else begin
          extra++;
        end
      end
      if (row_valid) begin
        if (exp_row_q.size() > 0) begin
          e_row = exp_row_q.pop_front();
          check("row_cycle_sel_data", 64'({8'(cyc), row_sel, row_out}), 64'(e_row));
        end else begin
          extra++;
        end
      end
`ifdef CONV_INPUT_CMD_CHECK_EN
      if (cmd_err) err_cnt++;
`endif
      if (frame_done && (ack == 2'd0)) frame_stray++;
      if (ack != 2'd0) begin
        got_ack = 1'b1;
        check("ack_code",   64'(ack),        64'(exp_ack));
        check("ack_cycle",  64'(cyc),        64'(ack_cyc));
        check("frame_done", 64'(frame_done), 64'(exp_frame));
        break;
      end
    end
    check("ack_seen",    64'(got_ack),          64'd1);
    check("rd_missing",  64'(exp_rd_q.size()),  64'd0);
    check("row_missing", 64'(exp_row_q.size()), 64'd0);
    check("extra_event", 64'(extra),            64'd0);
    check("frame_stray", 64'(frame_stray),      64'd0);
    exp_rd_q.delete();
    exp_row_q.delete();

    // Cycle after ack: ack must have dropped, FSM back in IDLE.
    @(negedge clk);
    cmd = CMD_IDLE;
`ifdef CONV_INPUT_CMD_CHECK_EN
    if (cmd_err) err_cnt++;
    check("cmd_err_count", 64'(err_cnt), 64'(exp_err));
`endif
    check("ack_one_cycle", 64'(ack), 64'd0);
  endtask

  // Reset raised in cycle 5 of a PRELOAD: command aborted, no ack.
  task automatic reset_mid_preload();
    int stray;
    stray = 0;
    cmd = CMD_PRELOAD;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      cmd = CMD_IDLE;
    end
    check("abort_rd_en",   64'(mem_rd_en),   64'd1);
    check("abort_rd_addr", 64'(mem_rd_addr), 64'((m_rb + 1)*W + 1));
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (ack != 2'd0 || mem_rd_en || frame_done) stray++;
    end
    check("abort_no_ack", 64'(stray), 64'd0);
    m_rb = 0; m_band = 0; m_col = 0;
    for (int r = 0; r < K; r++)
      for (int cc = 0; cc < K; cc++) m_win[r][cc] = 8'd0;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n_load;
    for (int a = 0; a < (1 << AW); a++) mem[a] = 8'(a);
    m_rb = 0; m_band = 0; m_col = 0;
    for (int r = 0; r < K; r++)
      for (int cc = 0; cc < K; cc++) m_win[r][cc] = 8'd0;

    rst = 1'b1;
    cmd = CMD_IDLE;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Band 0 preload, then two shifts: the window must not change.
    run_cmd(CMD_PRELOAD, 0, CMD_IDLE);
    run_cmd(CMD_SHIFT,   0, CMD_IDLE);
    run_cmd(CMD_SHIFT,   0, CMD_IDLE);

    // Three loads to the right edge, then an edge-case load.
    repeat (4) run_cmd(CMD_LOAD, 0, CMD_IDLE);
    run_cmd(CMD_SHIFT, 0, CMD_IDLE);

    // Bands 1, 2, 3; the last one wraps and pulses frame_done.
    repeat (3) run_cmd(CMD_PRELOAD, 0, CMD_IDLE);
    run_cmd(CMD_SHIFT, 0, CMD_IDLE);

    // Fifth preload starts at row 0; a SHIFT in cycle 4 must be ignored.
    run_cmd(CMD_PRELOAD, 4, CMD_SHIFT);
    run_cmd(CMD_SHIFT,   0, CMD_IDLE);

    // A random number of loads, possibly running into the right edge.
    n_load = $urandom_range(1, 4);
    repeat (n_load) run_cmd(CMD_LOAD, 0, CMD_IDLE);
    run_cmd(CMD_SHIFT, 0, CMD_IDLE);

    // Reset mid-preload; the cleared window and fresh band 0 follow.
    run_cmd(CMD_PRELOAD, 0, CMD_IDLE);
    reset_mid_preload();
    run_cmd(CMD_SHIFT,   0, CMD_IDLE);
    run_cmd(CMD_PRELOAD, 0, CMD_IDLE);
    run_cmd(CMD_SHIFT,   0, CMD_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
